// File: rtl/reg_file_pkg.sv
// Shared sizing and the writeback-buffer entry type for the register file.
// Optional unit-delay timing model: define REG_FILE_TIMING_EN.
package reg_file_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_REGS   = 8;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_file_wb_buffer.sv
// One-entry writeback buffer: captures a write each unstalled edge, holds under stall.
// Define REG_FILE_TIMING_EN for a #1 clock-to-state delay.
module wb_buffer
    import reg_file_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output wb_entry_t             o_entry
);

    wb_entry_t r_entry;
    wb_entry_t w_entry_nxt;

    always_comb begin
        w_entry_nxt = r_entry;
        if (i_rst) begin
            w_entry_nxt = '0;
        end else if (!i_stall) begin
            // Address/data are left stale when idle; only valid gates their use.
            if (i_write) begin
                w_entry_nxt.valid = 1'b1;
                w_entry_nxt.addr  = i_addr;
                w_entry_nxt.data  = i_data;
            end else begin
                w_entry_nxt.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
`ifdef REG_FILE_TIMING_EN
        r_entry <= #1 w_entry_nxt;
`else
        r_entry <= w_entry_nxt;
`endif
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/reg_file_wb.sv
// 8x8 register file feeding the ALU, with a bypassed one-entry writeback buffer.
// Define REG_FILE_TIMING_EN for the unit-delay timing model (#1 state, #2 reads).
module reg_file_wb
    import reg_file_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic                  BUSYWAIT,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    output logic                  WB_PENDING
);

    wb_entry_t                             w_wb;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   r_regs;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   w_regs_nxt;
    logic [DATA_WIDTH-1:0]                 w_out1;
    logic [DATA_WIDTH-1:0]                 w_out2;

    wb_buffer u_wb_buffer (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_stall (BUSYWAIT),
        .i_write (WRITE),
        .i_addr  (INADDRESS),
        .i_data  (IN),
        .o_entry (w_wb)
    );

    // Commit drains the buffer as it stood before this edge's capture.
    always_comb begin
        w_regs_nxt = r_regs;
        if (RESET) begin
            w_regs_nxt = '0;
        end else if (!BUSYWAIT && w_wb.valid) begin
            w_regs_nxt[w_wb.addr] = w_wb.data;
        end
    end

    always_ff @(posedge CLK) begin
`ifdef REG_FILE_TIMING_EN
        r_regs <= #1 w_regs_nxt;
`else
        r_regs <= w_regs_nxt;
`endif
    end

    assign w_out1 = (w_wb.valid && (w_wb.addr == OUT1ADDRESS)) ? w_wb.data : r_regs[OUT1ADDRESS];
    assign w_out2 = (w_wb.valid && (w_wb.addr == OUT2ADDRESS)) ? w_wb.data : r_regs[OUT2ADDRESS];

`ifdef REG_FILE_TIMING_EN
    assign #2 OUT1 = w_out1;
    assign #2 OUT2 = w_out2;
`else
    assign OUT1 = w_out1;
    assign OUT2 = w_out2;
`endif

    assign WB_PENDING = w_wb.valid;

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Eight-entry, 8-bit register file that sits directly upstream of the ALU.
- OUT1 and OUT2 drive the ALU DATA1 and DATA2 inputs; the ALU RESULT is written back through IN.
- Writes go through a one-entry writeback buffer with read bypass, so a result is readable the cycle after it is written.
- Writes commit only when the memory hierarchy is not stalling (BUSYWAIT low).

Parameters:
- DATA_WIDTH, 8, register and port data width.
- NUM_REGS, 8, number of architectural registers.
- ADDR_WIDTH, 3, register address width; must equal clog2(NUM_REGS).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
- IN  input  DATA_WIDTH  write data (ALU RESULT or memory load data).
- INADDRESS  input  ADDR_WIDTH  destination register.
- WRITE  input  1  write request for the current cycle.
- BUSYWAIT  input  1  stall from the memory hierarchy; freezes all state when high.
- OUT1ADDRESS  input  ADDR_WIDTH  read port 1 address.
- OUT2ADDRESS  input  ADDR_WIDTH  read port 2 address.
- OUT1  output  DATA_WIDTH  read port 1 data, to ALU DATA1.
- OUT2  output  DATA_WIDTH  read port 2 data, to ALU DATA2.
- WB_PENDING  output  1  writeback buffer holds an uncommitted write.

Behaviour:
- State: array regs[0..NUM_REGS-1]; buffer {wb_valid, wb_addr, wb_data}.
- Reset, on posedge CLK with RESET=1:
  - all regs, wb_valid, wb_addr and wb_data are cleared to 0.
  - RESET overrides WRITE and BUSYWAIT.
  - Reset mid-operation discards any pending buffered write.
  - After reset, OUT1, OUT2 and WB_PENDING read 0.
- Posedge with RESET=0 and BUSYWAIT=1: no state changes; the buffer and array hold their values.
- Posedge with RESET=0 and BUSYWAIT=0:
  - Commit: if wb_valid, then regs[wb_addr] <= wb_data.
  - Capture: if WRITE, then {wb_valid, wb_addr, wb_data} <= {1, INADDRESS, IN}; otherwise wb_valid <= 0.
  - Commit and capture happen on the same edge. The commit uses the old buffer contents, so back-to-back writes lose nothing.
- Reads are combinational (no clock):
  - OUTn = wb_data if wb_valid and OUTnADDRESS == wb_addr; otherwise regs[OUTnADDRESS].
  - The bypass always returns the newest value, including for back-to-back writes to the same address.
- Latency:
  - A write presented in cycle N is visible on OUTn after the posedge ending cycle N (via bypass).
  - It reaches the array one edge later, or later if stalled.
- No read-during-write hazard: reads never observe IN directly, only the buffer or the array.
- WB_PENDING = wb_valid.
- Out-of-range addresses cannot occur, because NUM_REGS = 2^ADDR_WIDTH.

Optional Feature:
- Macro: REG_FILE_TIMING_EN.
- Defined:
  - OUT1 and OUT2 update with #2 after any address, buffer or array change.
  - Buffer and array updates occur #1 after posedge CLK.
  - This matches the unit-delay timing model of the ALU stage.
- Undefined: zero-delay RTL, intended for synthesis and cycle-based checking.
- Functional cycle behaviour is identical in both builds.

Decomposition:
- Package reg_file_pkg contains:
  - DATA_WIDTH, NUM_REGS and ADDR_WIDTH localparams;
  - typedef wb_entry_t {logic valid; logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data}.
- Sub-module wb_buffer:
  - holds the wb_entry_t;
  - implements the capture, stall and reset rules;
  - exposes the entry to the parent for commit and bypass muxing.
- The array and the two read muxes stay in reg_file_wb.

Test Plan:
1. Reset: preload several registers, assert RESET for 1 cycle together with WRITE=1 and BUSYWAIT=1 → all reads return 0x00 and WB_PENDING=0 on the next cycle.
2. Write then read: WRITE r3=0x5A → the next cycle OUT1ADDRESS=3 gives 0x5A via bypass (WB_PENDING=1); one idle cycle later it gives 0x5A from the array (WB_PENDING=0).
3. Back-to-back same address: writes r2=0x11 then r2=0x22 on consecutive cycles → OUT2 at addr 2 reads 0x11, then 0x22; the final array value is 0x22.
4. Stall: capture r5=0xA0, then hold BUSYWAIT=1 for 3 cycles with WRITE r6=0xFF asserted → r5 stays bypassed as 0xA0, r6 remains 0x00, WB_PENDING stays 1; after release r5 commits.
5. Dual read with ALU: r1=0x05 and r4=0x04 committed, OUT1ADDRESS=1, OUT2ADDRESS=4 → OUT1=0x05 and OUT2=0x04; the downstream ALU add gives 0x09.
6. Reset mid-write: capture r7=0x3C, then RESET on the next edge → r7 reads 0x00 and the pending write is discarded.
